// File: rtl/axi4_wr_rd_traffic_gen.sv
// rtl/axi4_wr_rd_traffic_gen.sv - AXI4 master issuing per-region write bursts, then read-back bursts checked against the written counter
module axi4_wr_rd_traffic_gen #(
  parameter int                    ADDR_WIDTH    = 32,
  parameter int                    DATA_WIDTH    = 32,
  parameter int                    ID_WIDTH      = 1,
  parameter int                    NUM_REGIONS   = 4,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR     = 'h100,
  parameter logic [ADDR_WIDTH-1:0] REGION_STRIDE = 'h100,
  parameter int                    MAX_BEATS     = 8,
  parameter int                    NUM_ITER      = 100
) (
  input  logic                    ACLK,
  input  logic                    ARESETN,
  input  logic                    start,
  input  logic                    stop,
  output logic                    busy,
  output logic                    done,
  output logic                    error,
  output logic [15:0]             err_count,
  output logic [ID_WIDTH-1:0]     M_AXI_AWID,
  output logic [ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic [7:0]              M_AXI_AWLEN,
  output logic [2:0]              M_AXI_AWSIZE,
  output logic [1:0]              M_AXI_AWBURST,
  output logic                    M_AXI_AWVALID,
  input  logic                    M_AXI_AWREADY,
  output logic [DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                    M_AXI_WLAST,
  output logic                    M_AXI_WVALID,
  input  logic                    M_AXI_WREADY,
  input  logic [ID_WIDTH-1:0]     M_AXI_BID,
  input  logic [1:0]              M_AXI_BRESP,
  input  logic                    M_AXI_BVALID,
  output logic                    M_AXI_BREADY,
  output logic [ID_WIDTH-1:0]     M_AXI_ARID,
  output logic [ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic [7:0]              M_AXI_ARLEN,
  output logic [2:0]              M_AXI_ARSIZE,
  output logic [1:0]              M_AXI_ARBURST,
  output logic                    M_AXI_ARVALID,
  input  logic                    M_AXI_ARREADY,
  input  logic [ID_WIDTH-1:0]     M_AXI_RID,
  input  logic [DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]              M_AXI_RRESP,
  input  logic                    M_AXI_RLAST,
  input  logic                    M_AXI_RVALID,
  output logic                    M_AXI_RREADY
);
  localparam int RW = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;
  localparam logic [RW-1:0] LAST_REGION = RW'(NUM_REGIONS - 1);

  typedef enum logic [2:0] {IDLE, WR_ADDR, WR_DATA, WR_RESP, RD_ADDR, RD_DATA, NEXT, FIN} state_t;

  state_t                state_q, state_d;
  logic [RW-1:0]         region_q, region_d, nxt_region;
  logic [7:0]            beat_q, beat_d, len_q, len_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [15:0]           wcount_q, wcount_d;
  logic [31:0]           iter_q, iter_d;
  logic                  stop_seen_q, stop_seen_d;
  logic [15:0]           err_q, err_d;
  logic [15:0]           start_val_q [NUM_REGIONS];
  logic                  sv_we, err_clr, last_region, last_beat, data_err;
  logic [1:0]            err_inc;
  logic [15:0]           rd_exp;
  logic [16:0]           err_sum;

  function automatic logic [7:0] len_of(input logic [RW-1:0] r);
    int b;
    b = MAX_BEATS >> r;
    if (b < 1) b = 1;
    return 8'(b - 1);
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] addr_of(input logic [RW-1:0] r);
    return BASE_ADDR + ADDR_WIDTH'(r) * REGION_STRIDE;
  endfunction

  assign last_region = (region_q == LAST_REGION);
  assign nxt_region  = last_region ? '0 : region_q + 1'b1;
  assign last_beat   = (beat_q == len_q);
  assign rd_exp      = start_val_q[region_q] + 16'(beat_q);
  assign data_err    = (M_AXI_RDATA != {{(DATA_WIDTH-16){1'b0}}, rd_exp});
  assign err_sum     = {1'b0, err_q} + 17'(err_inc);

  always_comb begin
    state_d     = state_q;
    region_d    = region_q;
    beat_d      = beat_q;
    len_d       = len_q;
    addr_d      = addr_q;
    wcount_d    = wcount_q;
    iter_d      = iter_q;
    stop_seen_d = stop_seen_q | (stop && (state_q != IDLE));
    sv_we       = 1'b0;
    err_clr     = 1'b0;
    err_inc     = 2'd0;
    case (state_q)
      IDLE: if (start) begin
        state_d     = WR_ADDR;
        region_d    = '0;
        beat_d      = 8'd0;
        len_d       = len_of('0);
        addr_d      = addr_of('0);
        wcount_d    = 16'd0;
        iter_d      = 32'd0;
        stop_seen_d = 1'b0;
        err_clr     = 1'b1;
      end
      WR_ADDR: if (M_AXI_AWREADY) begin
        state_d = WR_DATA;
        beat_d  = 8'd0;
      end
      WR_DATA: if (M_AXI_WREADY) begin
        wcount_d = wcount_q + 16'd1;
        sv_we    = (beat_q == 8'd0);
        beat_d   = beat_q + 8'd1;
        if (last_beat) state_d = WR_RESP;
      end
      WR_RESP: if (M_AXI_BVALID) begin
        err_inc  = 2'(M_AXI_BRESP != 2'b00);
        region_d = nxt_region;
        len_d    = len_of(nxt_region);
        addr_d   = addr_of(nxt_region);
        state_d  = last_region ? RD_ADDR : WR_ADDR;
      end
      RD_ADDR: if (M_AXI_ARREADY) begin
        state_d = RD_DATA;
        beat_d  = 8'd0;
      end
      RD_DATA: if (M_AXI_RVALID) begin
        // RLAST is only checked; the burst length we issued decides where it ends
        err_inc = 2'(data_err) + 2'(M_AXI_RRESP != 2'b00) + 2'(M_AXI_RLAST != last_beat);
        beat_d  = beat_q + 8'd1;
        if (last_beat) begin
          region_d = nxt_region;
          len_d    = len_of(nxt_region);
          addr_d   = addr_of(nxt_region);
          state_d  = last_region ? NEXT : RD_ADDR;
        end
      end
      NEXT: begin
        iter_d  = iter_q + 32'd1;
        state_d = (((NUM_ITER != 0) && (iter_d == 32'(NUM_ITER))) || stop_seen_q || stop) ? FIN : WR_ADDR;
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    err_d = err_clr ? 16'd0 : (err_sum[16] ? 16'hFFFF : err_sum[15:0]);
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      state_q     <= IDLE;
      region_q    <= '0;
      beat_q      <= 8'd0;
      len_q       <= 8'd0;
      addr_q      <= '0;
      wcount_q    <= 16'd0;
      iter_q      <= 32'd0;
      stop_seen_q <= 1'b0;
      err_q       <= 16'd0;
      for (int i = 0; i < NUM_REGIONS; i++) start_val_q[i] <= 16'd0;
    end else begin
      state_q     <= state_d;
      region_q    <= region_d;
      beat_q      <= beat_d;
      len_q       <= len_d;
      addr_q      <= addr_d;
      wcount_q    <= wcount_d;
      iter_q      <= iter_d;
      stop_seen_q <= stop_seen_d;
      err_q       <= err_d;
      if (sv_we) start_val_q[region_q] <= wcount_q;
    end
  end

  // Channel controls are pure functions of the registered state, so payloads cannot move while VALID waits
  assign busy          = (state_q != IDLE) && (state_q != FIN);
  assign done          = (state_q == FIN);
  assign error         = (err_q != 16'd0);
  assign err_count     = err_q;
  assign M_AXI_AWID    = '0;
  assign M_AXI_AWADDR  = addr_q;
  assign M_AXI_AWLEN   = len_q;
  assign M_AXI_AWSIZE  = 3'($clog2(DATA_WIDTH/8));
  assign M_AXI_AWBURST = 2'd1;
  assign M_AXI_AWVALID = (state_q == WR_ADDR);
  assign M_AXI_WDATA   = {{(DATA_WIDTH-16){1'b0}}, wcount_q};
  assign M_AXI_WSTRB   = '1;
  assign M_AXI_WLAST   = (state_q == WR_DATA) && last_beat;
  assign M_AXI_WVALID  = (state_q == WR_DATA);
  assign M_AXI_BREADY  = (state_q == WR_RESP);
  assign M_AXI_ARID    = '0;
  assign M_AXI_ARADDR  = addr_q;
  assign M_AXI_ARLEN   = len_q;
  assign M_AXI_ARSIZE  = 3'($clog2(DATA_WIDTH/8));
  assign M_AXI_ARBURST = 2'd1;
  assign M_AXI_ARVALID = (state_q == RD_ADDR);
  assign M_AXI_RREADY  = (state_q == RD_DATA);

  logic unused_ids;
  assign unused_ids = &{1'b0, M_AXI_BID, M_AXI_RID};
endmodule
